// File: rtl/connect_count_feeder.sv
// connect_count_feeder: FIFO-buffered graph feeder with fixed-latency start/count pipelines; CONNECT_COUNT_FEEDER_STATS_EN enables served/starved counters
module connect_count_feeder #(
  parameter int EXTRA_DATA_WIDTH = 10,
  parameter int DATA_IN_LATENCY = 4,
  parameter int STARTING_CONNECT_COUNT_LAG = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        graphValid,
  output logic                        graphReady,
  input  logic [127:0]                graphData,
  input  logic [5:0]                  graphStartCount,
  input  logic [EXTRA_DATA_WIDTH-1:0] graphExtra,
  input  logic                        request,
  output logic [127:0]                graphIn,
  output logic                        start,
  output logic [EXTRA_DATA_WIDTH-1:0] extraDataIn,
  output logic [5:0]                  startingConnectCountIn_DELAYED,
  output logic [4:0]                  fifoCount,
  output logic [31:0]                 starvedCount,
  output logic [31:0]                 servedCount
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = 128 + EXTRA_DATA_WIDTH;
  localparam int L = DATA_IN_LATENCY;
  localparam int CL = DATA_IN_LATENCY + STARTING_CONNECT_COUNT_LAG;
  logic [DW+5:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [4:0] r_count;
  logic [L-1:0] r_vld;
  logic [DW-1:0] r_dat [L];
  logic [5:0] r_cnt [CL];
  logic w_push, w_pop;
  logic [DW+5:0] w_head;
  assign w_head = r_mem[r_rd];
  assign graphReady = !rst && r_count != 5'(FIFO_DEPTH);
  assign w_push = graphValid && graphReady;
  assign w_pop = !rst && request && r_count != 5'd0;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= {graphStartCount, graphExtra, graphData};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      r_wr <= r_wr + AW'(w_push);
      r_rd <= r_rd + AW'(w_pop);
      r_count <= r_count + 5'(w_push) - 5'(w_pop);
    end
  end
  // Stages carry zeros on bubbles, so the tail of each pipe is already the output value
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < L; i++) r_dat[i] <= '0;
      for (int i = 0; i < CL; i++) r_cnt[i] <= '0;
    end else begin
      r_vld <= {r_vld[L-2:0], w_pop};
      r_dat[0] <= w_pop ? w_head[DW-1:0] : '0;
      for (int i = 1; i < L; i++) r_dat[i] <= r_dat[i-1];
      r_cnt[0] <= w_pop ? w_head[DW+5:DW] : '0;
      for (int i = 1; i < CL; i++) r_cnt[i] <= r_cnt[i-1];
    end
  end
  assign start = !rst && r_vld[L-1];
  assign {extraDataIn, graphIn} = rst ? '0 : r_dat[L-1];
  assign startingConnectCountIn_DELAYED = rst ? '0 : r_cnt[CL-1];
  assign fifoCount = rst ? '0 : r_count;
`ifdef CONNECT_COUNT_FEEDER_STATS_EN
  logic [31:0] r_served, r_starved;
  logic w_bubble;
  assign w_bubble = !rst && request && r_count == 5'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_served <= '0;
      r_starved <= '0;
    end else begin
      r_served <= r_served + 32'(w_pop);
      r_starved <= r_starved + 32'(w_bubble);
    end
  end
  assign servedCount = rst ? '0 : r_served;
  assign starvedCount = rst ? '0 : r_starved;
`else
  assign servedCount = '0;
  assign starvedCount = '0;
`endif
endmodule

// File: tb/tb_connect_count_feeder.sv
// tb_connect_count_feeder: random and directed stimulus checked every cycle against a queue-based model
module tb_connect_count_feeder;
  localparam int EW = 10, L = 4, S = 3, DEPTH = 4, NC = 2400;
`ifdef CONNECT_COUNT_FEEDER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0, rst, graphValid, graphReady, request, start;
  logic [127:0] graphData, graphIn;
  logic [5:0] graphStartCount, startingConnectCountIn_DELAYED;
  logic [EW-1:0] graphExtra, extraDataIn;
  logic [4:0] fifoCount;
  logic [31:0] starvedCount, servedCount;
  connect_count_feeder #(.EXTRA_DATA_WIDTH(EW), .DATA_IN_LATENCY(L), .STARTING_CONNECT_COUNT_LAG(S), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .graphValid(graphValid), .graphReady(graphReady), .graphData(graphData),
    .graphStartCount(graphStartCount), .graphExtra(graphExtra), .request(request), .graphIn(graphIn),
    .start(start), .extraDataIn(extraDataIn), .startingConnectCountIn_DELAYED(startingConnectCountIn_DELAYED),
    .fifoCount(fifoCount), .starvedCount(starvedCount), .servedCount(servedCount));
  always #5 clk = ~clk;
  typedef struct {logic [127:0] g; logic [5:0] c; logic [EW-1:0] x;} ent_t;
  ent_t q[$];
  bit e_st [NC];
  bit [127:0] e_g [NC];
  bit [EW-1:0] e_x [NC];
  bit [5:0] e_c [NC];
  int cyc = 0, n_chk = 0, n_fail = 0;
  int lit_req = -100, lit_bub = -100, lit_rst = -100;
  logic [31:0] m_served = 0, m_starved = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", n, cyc, a, e);
    end
  endtask
  always @(negedge clk) begin : model
    int sz;
    ent_t e;
    sz = q.size();
    chk("graphReady", graphReady, !rst && sz < DEPTH);
    chk("fifoCount", fifoCount, rst ? 0 : sz);
    chk("start", start, rst ? 1'b0 : e_st[cyc]);
    chk("graphIn", graphIn, rst ? '0 : e_g[cyc]);
    chk("extraDataIn", extraDataIn, rst ? '0 : e_x[cyc]);
    chk("countDelayed", startingConnectCountIn_DELAYED, rst ? '0 : e_c[cyc]);
    chk("servedCount", servedCount, (rst || !STATS) ? 0 : m_served);
    chk("starvedCount", starvedCount, (rst || !STATS) ? 0 : m_starved);
    if (cyc == lit_req + L) begin
      chk("lit_start", start, 1);
      chk("lit_graphIn", graphIn, 1);
      chk("lit_extra", extraDataIn, 'h3A);
    end
    if (cyc == lit_req + L + S) chk("lit_count", startingConnectCountIn_DELAYED, 5);
    if (cyc == lit_bub + L) begin
      chk("lit_bubble_start", start, 0);
      chk("lit_bubble_graphIn", graphIn, 0);
    end
    if (cyc > lit_rst && cyc <= lit_rst + 7) chk("lit_rst_start", start, 0);
    if (rst) begin
      q.delete();
      m_served = 0;
      m_starved = 0;
      for (int j = cyc; j < cyc + L + S + 2 && j < NC; j++) begin
        e_st[j] = 0; e_g[j] = 0; e_x[j] = 0; e_c[j] = 0;
      end
    end else begin
      if (request && sz > 0) begin
        e = q.pop_front();
        e_st[cyc+L] = 1; e_g[cyc+L] = e.g; e_x[cyc+L] = e.x; e_c[cyc+L+S] = e.c;
        m_served++;
      end else if (request) m_starved++;
      if (graphValid && sz < DEPTH) q.push_back('{graphData, graphStartCount, graphExtra});
    end
  end
  task automatic cyc_in(input logic v, input logic [127:0] g, input logic [5:0] c, input logic [EW-1:0] x, input logic rq, input logic r);
    graphValid = v; graphData = g; graphStartCount = c; graphExtra = x; request = rq; rst = r;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc_in(0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    int dens;
    cyc_in(0, 0, 0, 0, 0, 1);
    repeat (3) cyc_in(0, 0, 0, 0, 0, 1);
    idle(2);
    cyc_in(1, 1, 5, 'h3A, 0, 0);
    lit_req = cyc;
    cyc_in(0, 0, 0, 0, 1, 0);
    idle(10);
    lit_bub = cyc;
    cyc_in(0, 0, 0, 0, 1, 0);
    idle(6);
    chk("starved_after_bubble", starvedCount, STATS ? 1 : 0);
    for (int i = 0; i < 4; i++) cyc_in(1, 128'h10 + 128'(i), 6'(i), EW'(i), 0, 0);
    chk("full_fifoCount", fifoCount, 4);
    chk("full_graphReady", graphReady, 0);
    cyc_in(1, 'h99, 9, 'h99, 0, 0);
    cyc_in(1, 'h99, 9, 'h99, 0, 0);
    cyc_in(1, 'h99, 9, 'h99, 1, 0);
    chk("pop_full_fifoCount", fifoCount, 3);
    cyc_in(1, 'h99, 9, 'h99, 0, 0);
    chk("fifth_accepted", fifoCount, 4);
    repeat (4) cyc_in(0, 0, 0, 0, 1, 0);
    cyc_in(0, 0, 0, 0, 1, 0);
    idle(8);
    chk("drained", fifoCount, 0);
    cyc_in(1, 'hA, 1, 'h0A, 0, 0);
    cyc_in(1, 'hB, 2, 'h0B, 0, 0);
    cyc_in(1, 'hC, 3, 'h0C, 0, 0);
    repeat (3) cyc_in(0, 0, 0, 0, 1, 0);
    idle(8);
    chk("served_total", servedCount, STATS ? 9 : 0);
    cyc_in(1, 'hD, 4, 'h0D, 0, 0);
    lit_rst = cyc;
    cyc_in(0, 0, 0, 0, 1, 0);
    cyc_in(1, 'hE, 4, 'h0E, 1, 1);
    cyc_in(1, 'hE, 4, 'h0E, 1, 1);
    idle(6);
    chk("rst_fifoCount", fifoCount, 0);
    chk("rst_served", servedCount, 0);
    chk("rst_starved", starvedCount, 0);
    dens = 50;
    for (int i = 0; i < 1500; i++) begin
      if (i % 200 == 0) dens = 20 + 35 * (i / 200 % 3);
      cyc_in($urandom_range(0, 99) < 60, {$urandom, $urandom, $urandom, $urandom}, 6'($urandom),
             EW'($urandom), $urandom_range(0, 99) < dens, $urandom_range(0, 299) == 0);
    end
    idle(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/connect_count_feeder.md
CONNECT_COUNT_FEEDER -- requirements
Module: connectCountFeeder

Interface
REQ-001 SHALL have parameter EXTRA_DATA_WIDTH, default 10: width of the per-graph tag.
REQ-002 SHALL have parameter DATA_IN_LATENCY, default 4, legal range 2..16: cycles from core request to start.
REQ-003 SHALL have parameter STARTING_CONNECT_COUNT_LAG, default 3, legal range 1..8: cycles from start to the starting count.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, a power of two in the range 2..16: number of upstream entries buffered.
REQ-005 clk  in  1  sole clock; all logic on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 graphValid  in  1  upstream offers an entry.
REQ-008 graphReady  out  1  feeder accepts an entry this cycle.
REQ-009 graphData  in  128  upstream graph.
REQ-010 graphStartCount  in  6  upstream initial connect count.
REQ-011 graphExtra  in  EXTRA_DATA_WIDTH  upstream tag.
REQ-012 request  in  1  core slot request.
REQ-013 graphIn  out  128  graph to the core.
REQ-014 start  out  1  graphIn and extraDataIn are valid.
REQ-015 extraDataIn  out  EXTRA_DATA_WIDTH  tag to the core.
REQ-016 startingConnectCountIn_DELAYED  out  6  initial count, presented after the start lag.
REQ-017 fifoCount  out  5  current buffer occupancy.
REQ-018 starvedCount  out  32  requests that found the buffer empty.
REQ-019 servedCount  out  32  requests that were served.

Function
REQ-020 An upstream handshake SHALL occur on any cycle where graphValid and graphReady are both 1.
REQ-021 graphReady SHALL equal !full; a pop in the same cycle SHALL NOT free a slot for that cycle's push.
REQ-022 An entry pushed at cycle t SHALL first become poppable at t+1; there is no empty-FIFO bypass.
REQ-023 When request is 1 at cycle t and the buffer is non-empty, the feeder SHALL pop the oldest entry at t (FIFO order).
REQ-024 For a pop at cycle t, start SHALL be 1 at t+DATA_IN_LATENCY, with graphIn and extraDataIn carrying the popped entry.
REQ-025 For a pop at cycle t, startingConnectCountIn_DELAYED SHALL carry the popped count at t+DATA_IN_LATENCY+STARTING_CONNECT_COUNT_LAG.
REQ-026 A request at cycle t on an empty buffer SHALL be a bubble: start=0 at t+DATA_IN_LATENCY, and the request is not retained.
REQ-027 Whenever start=0, graphIn and extraDataIn SHALL be 0.
REQ-028 Whenever no count is being presented on startingConnectCountIn_DELAYED, it SHALL be 0.
REQ-029 Requests on consecutive cycles SHALL each be served independently; the feeder sustains one pop per cycle.
REQ-030 A simultaneous push and pop SHALL leave fifoCount unchanged, with push and pop pointers wrapping modulo FIFO_DEPTH.
REQ-031 fifoCount SHALL be registered, in the range 0..FIFO_DEPTH, and full when fifoCount==FIFO_DEPTH.

Reset
REQ-032 While rst=1, graphReady SHALL be 0, and request and graphValid SHALL be ignored.
REQ-033 Reset SHALL empty the buffer and set fifoCount=0.
REQ-034 Reset SHALL clear every delay stage, so start=0 on every cycle from the first cycle of reset through DATA_IN_LATENCY cycles after rst deasserts.
REQ-035 A pop issued before reset whose output would emerge after reset SHALL be discarded; reset mid-flight never produces a late start.
REQ-036 Reset SHALL clear starvedCount and servedCount to 0, and all outputs SHALL be 0 during reset.

Configuration
REQ-037 The feature macro SHALL be named CONNECT_COUNT_FEEDER_STATS_EN.
REQ-038 With CONNECT_COUNT_FEEDER_STATS_EN defined, servedCount SHALL increment per pop and starvedCount per bubble, both wrapping at 2^32.
REQ-039 Without CONNECT_COUNT_FEEDER_STATS_EN, both counters SHALL be tied to constant 0 and no counter registers SHALL be synthesized.
REQ-040 The ports of REQ-018 and REQ-019 SHALL exist in both builds.

Verification
REQ-041 Default parameters; push entry {G=0x1, cnt=5, extra=0x3A}; request at cycle 10 -> start=1, graphIn=0x1, extraDataIn=0x3A at cycle 14; startingConnectCountIn_DELAYED=5 at cycle 17.
REQ-042 Empty buffer; request at cycle 20 -> start=0 and graphIn=0 at cycle 24; starvedCount=1 (STATS_EN build).
REQ-043 Push 4 entries with graphValid held high -> fifoCount=4 and graphReady=0; the fifth entry is held until a pop, then accepted on the next cycle.
REQ-044 Push A,B,C; requests at cycles 30,31,32 -> start=1 at 34,35,36 carrying A,B,C in order; servedCount=3.
REQ-045 Pop at cycle 40; rst=1 for cycles 41-42 -> start stays 0 through cycle 46; fifoCount=0; both counters 0.
REQ-046 Non-STATS_EN build; 10 pops and 3 bubbles -> servedCount=0 and starvedCount=0.
